// File: rtl/lfsr_rr_sched.sv
// lfsr_rr_sched: one 8-bit Fibonacci LFSR shared by two requesters through a
// round-robin req/ack handshake. Every grant advances the LFSR one step and
// hands the fresh value to the winner only. The block also handles seed
// loading, keeps the register out of the all-zero lockup state, and measures
// the period relative to the loaded seed.
module lfsr_rr_sched #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       seed_we,
    input  logic [7:0] seed_din,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rnd,
    output logic       busy,
    output logic       period_stb,
    output logic [7:0] period_len
);

    typedef enum logic [1:0] {IDLE, STEP, GRANT} state_t;

    // One Fibonacci step: feedback from taps 4,3,2,0 enters at the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

    // All-zero is a lockup state for this LFSR, so it is never stored.
    function automatic logic [7:0] zero_guard(input logic [7:0] v);
        return (v == 8'h00) ? 8'h01 : v;
    endfunction

    localparam logic [7:0] SEED_SAFE = zero_guard(SEED);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_nxt;
    logic [7:0] seed_reg;
    logic [7:0] cnt;
    logic       sel;
    logic       last;
    logic       win;
    logic       any_req;
    logic       period_hit;

    // Next LFSR value, period match and round-robin winner selection.
    always_comb begin
        lfsr_nxt   = lfsr_step(lfsr);
        period_hit = (lfsr_nxt == seed_reg);
        any_req    = req0 | req1;
        // On a tie the requester that was not served last wins.
        win        = (req0 && req1) ? ~last : req1;
    end

    // Next-state logic; a seed write in IDLE takes priority over requests.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!seed_we && any_req) state_nxt = STEP;
            STEP:    state_nxt = GRANT;
            GRANT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // LFSR, seed, period tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= SEED_SAFE;
            seed_reg   <= SEED_SAFE;
            cnt        <= 8'h00;
            sel        <= 1'b0;
            last       <= 1'b1;
            rnd        <= 8'h00;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            period_stb <= 1'b0;
            period_len <= 8'h00;
        end else begin
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            period_stb <= 1'b0;
            // busy follows the state being entered so it lines up with STEP/GRANT.
            busy       <= (state_nxt != IDLE);
            unique case (state)
                IDLE: begin
                    if (seed_we) begin
                        lfsr     <= zero_guard(seed_din);
                        seed_reg <= zero_guard(seed_din);
                        cnt      <= 8'h00;
                    end else if (any_req) begin
                        sel <= win;
                    end
                end
                STEP: begin
                    lfsr <= lfsr_nxt;
                    rnd  <= lfsr_nxt;
                    ack0 <= ~sel;
                    ack1 <= sel;
                    // A period is at most 255 steps, so cnt+1 always fits.
                    if (period_hit) begin
                        period_len <= cnt + 8'd1;
                        period_stb <= 1'b1;
                        cnt        <= 8'h00;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GRANT: begin
                    last <= sel;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Testbench for lfsr_rr_sched: per-cycle vector table for handshake, seeding
// and reset behaviour, then a hand-written run across two full periods.
module tb_lfsr_rr_sched;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       req1;
    logic       seed_we;
    logic [7:0] seed_din;
    logic       ack0;
    logic       ack1;
    logic [7:0] rnd;
    logic       busy;
    logic       period_stb;
    logic [7:0] period_len;

    int checks = 0;
    int errors = 0;

    lfsr_rr_sched #(.SEED(8'h01)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .seed_we    (seed_we),
        .seed_din   (seed_din),
        .ack0       (ack0),
        .ack1       (ack1),
        .rnd        (rnd),
        .busy       (busy),
        .period_stb (period_stb),
        .period_len (period_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       r0;
        logic       r1;
        logic       swe;
        logic [7:0] sdin;
        logic       a0;
        logic       a1;
        logic       bsy;
        logic       pstb;
        logic [7:0] rnd;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] model_step(input logic [7:0] s);
        return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic add(input logic rs, input logic r0, input logic r1, input logic swe,
                       input logic [7:0] sdin, input logic a0, input logic a1,
                       input logic bsy, input logic pstb, input logic [7:0] r);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.r1 = r1; v.swe = swe; v.sdin = sdin;
        v.a0 = a0; v.a1 = a1; v.bsy = bsy; v.pstb = pstb; v.rnd = r;
        vecs.push_back(v);
    endtask

    // One full transaction with requests held: IDLE->STEP, STEP->GRANT, GRANT->IDLE.
    task automatic add_grant(input logic r0, input logic r1, input logic winner,
                             input logic [7:0] prev, input logic [7:0] nxt);
        add(1'b0, r0, r1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, prev);
        add(1'b0, r0, r1, 1'b0, 8'h00, ~winner, winner, 1'b1, 1'b0, nxt);
        add(1'b0, r0, r1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, nxt);
    endtask

    initial begin
        logic [7:0] expv;
        logic [7:0] s;
        int         per;
        int         g;
        logic       done;

        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; seed_we = 1'b0; seed_din = 8'h00;

        // Reset state
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        // req0 alone for five grants
        add_grant(1'b1, 1'b0, 1'b0, 8'h00, 8'h80);
        add_grant(1'b1, 1'b0, 1'b0, 8'h80, 8'h40);
        add_grant(1'b1, 1'b0, 1'b0, 8'h40, 8'h20);
        add_grant(1'b1, 1'b0, 1'b0, 8'h20, 8'h10);
        add_grant(1'b1, 1'b0, 1'b0, 8'h10, 8'h88);
        // Both held from reset: alternate 0,1,0,1
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        add_grant(1'b1, 1'b1, 1'b0, 8'h00, 8'h80);
        add_grant(1'b1, 1'b1, 1'b1, 8'h80, 8'h40);
        add_grant(1'b1, 1'b1, 1'b0, 8'h40, 8'h20);
        add_grant(1'b1, 1'b1, 1'b1, 8'h20, 8'h10);
        // Seed 00 in IDLE (beats req0 this cycle) is stored as 01
        add(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10);
        add_grant(1'b0, 1'b1, 1'b1, 8'h10, 8'h80);
        // seed_we in STEP/GRANT ignored; req0 dropped after latch still acked
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 8'h40);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
        // seed_we in IDLE loads 5A; step(5A) = 2D
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40);
        add_grant(1'b1, 1'b0, 1'b0, 8'h40, 8'h2D);
        // Tie after req0 was served: req1 wins; step(2D) = 96
        add_grant(1'b1, 1'b1, 1'b1, 8'h2D, 8'h96);
        // Reset asserted during GRANT: no lingering ack, LFSR back to seed
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h96);
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4B);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        add_grant(1'b1, 1'b0, 1'b0, 8'h00, 8'h80);
        // Reset asserted during STEP: the transaction is dropped
        add(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        add_grant(1'b1, 1'b0, 1'b0, 8'h00, 8'h80);

        foreach (vecs[i]) begin
            rst      = vecs[i].rst;
            req0     = vecs[i].r0;
            req1     = vecs[i].r1;
            seed_we  = vecs[i].swe;
            seed_din = vecs[i].sdin;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d ack0", i), {7'd0, ack0}, {7'd0, vecs[i].a0});
            chk($sformatf("v%0d ack1", i), {7'd0, ack1}, {7'd0, vecs[i].a1});
            chk($sformatf("v%0d busy", i), {7'd0, busy}, {7'd0, vecs[i].bsy});
            chk($sformatf("v%0d period_stb", i), {7'd0, period_stb}, {7'd0, vecs[i].pstb});
            chk($sformatf("v%0d rnd", i), rnd, vecs[i].rnd);
        end

        // Period length from the step function itself
        s = model_step(8'h01);
        per = 1;
        while (s != 8'h01 && per < 300) begin
            s = model_step(s);
            per++;
        end

        // Two consecutive periods from seed 01 with req0 held
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; seed_we = 1'b0; seed_din = 8'h00;
        @(posedge clk);
        #1;
        chk("per reset len", period_len, 8'h00);
        rst  = 1'b0;
        req0 = 1'b1;
        expv = 8'h01;
        for (int p = 0; p < 2; p++) begin
            g = 0;
            done = 1'b0;
            for (int cyc = 0; cyc < 900 && !done; cyc++) begin
                @(posedge clk);
                #1;
                if (ack0) begin
                    expv = model_step(expv);
                    g++;
                    chk("per rnd", rnd, expv);
                    chk("per stb", {7'd0, period_stb}, {7'd0, (expv == 8'h01)});
                    chk("per ack1", {7'd0, ack1}, 8'h00);
                    if (expv == 8'h01) begin
                        chk("per len grants", period_len, g[7:0]);
                        chk("per len model", period_len, per[7:0]);
                        done = 1'b1;
                    end else begin
                        chk("per len hold", period_len, (p == 0) ? 8'h00 : per[7:0]);
                    end
                end else begin
                    chk("per stb outside ack", {7'd0, period_stb}, 8'h00);
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL per timeout: period %0d not completed after %0d grants", p, g);
            end
        end
        req0 = 1'b0;
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
